// File: rtl/mem_pkg.sv
// Shared definitions for mem_access_unit: access-size encodings, FSM states, size helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus RAM strobe bus of mem_access_unit.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_fault;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_size;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_cs, mem_we, mem_oe, mem_addr, mem_size, mem_wdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_cs, mem_we, mem_oe, mem_addr, mem_size, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Combinational load-data extension: keep the low 8/16/32/64 bits, zero- or sign-fill above.
module load_extender
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] ext
);

  always_comb begin
    ext = data;
    unique case (size)
      SIZE_B:  ext = {{(DATA_WIDTH-8){is_signed & data[7]}}, data[7:0]};
      SIZE_H:  ext = {{(DATA_WIDTH-16){is_signed & data[15]}}, data[15:0]};
      SIZE_W:  ext = {{(DATA_WIDTH-32){is_signed & data[31]}}, data[31:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving a wait-stated RAM strobe bus.
// MEM_ALIGN_CHECK_EN: fault misaligned requests instead of aligning the address down.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input logic              clock,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q;
  logic                  wr_q, sgn_q, fault_q;
  size_e                 size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, ext_data;
  logic [ADDR_WIDTH-1:0] lsb_mask;
  logic                  accept, misaligned, access_last;

  assign lsb_mask    = ADDR_WIDTH'(size_bytes(bus.req_size) - 4'd1);
  assign accept      = bus.req_valid && (state_q == IDLE);
  assign access_last = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |(bus.req_addr & lsb_mask);
`else
  assign misaligned = 1'b0;
`endif

  load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .data      (bus.mem_rdata),
    .size      (size_q),
    .is_signed (sgn_q),
    .ext       (ext_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_fault = 1'b0;
    bus.mem_cs     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_oe     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_size   = '0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (accept) state_d = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = wr_q;
        bus.mem_oe    = !wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_size  = size_q;
        bus.mem_wdata = wdata_q;
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data is extended on the way in, so resp_rdata simply holds until the next response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= 3'(WAIT_STATES);
        wr_q    <= bus.req_write;
        sgn_q   <= bus.req_signed;
        fault_q <= misaligned;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr & ~lsb_mask;
        wdata_q <= bus.req_wdata;
      end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (access_last)                rdata_q <= wr_q ? '0 : ext_data;
      else if (accept && misaligned)  rdata_q <= '0;
    end
  end

  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (WAIT_STATES 0/1/3) on shared stimulus, one selected for checking.
module tb_mem_access_unit;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic [152:0] outs [3];
  int           sel = 0;
  logic         o_ready, o_valid, o_fault, o_busy, o_cs, o_we, o_oe;
  logic [1:0]   o_size;
  logic [15:0]  o_addr;
  logic [63:0]  o_wdata, o_rdata;

  int          checks = 0, passed = 0, failed = 0;
  logic [63:0] last_rdata = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) bus ();
    assign bus.req_valid  = req_valid;
    assign bus.req_write  = req_write;
    assign bus.req_size   = req_size;
    assign bus.req_signed = req_signed;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.mem_rdata  = mem_rdata;
    mem_access_unit #(
      .DATA_WIDTH (64),
      .ADDR_WIDTH (16),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
    );
    assign outs[g] = {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.busy,
                      bus.mem_cs, bus.mem_we, bus.mem_oe, bus.mem_size,
                      bus.mem_addr, bus.mem_wdata, bus.resp_rdata};
  end

  assign {o_ready, o_valid, o_fault, o_busy, o_cs, o_we, o_oe,
          o_size, o_addr, o_wdata, o_rdata} = outs[sel];

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
  endfunction

  // Reference extension from the size's bit count with plain masking arithmetic.
  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input logic sg);
    int unsigned bits;
    logic [63:0] mask, v;
    bits = 8 << sz;
    mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v = d & mask;
    if (sg && bits < 64 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_ready", o_ready, 1);  chk("rst_valid", o_valid, 0);
    chk("rst_fault", o_fault, 0);  chk("rst_busy", o_busy, 0);
    chk("rst_cs", o_cs, 0);        chk("rst_we", o_we, 0);
    chk("rst_oe", o_oe, 0);        chk("rst_addr", o_addr, 0);
    chk("rst_size", o_size, 0);    chk("rst_wdata", o_wdata, 0);
    chk("rst_rdata", o_rdata, 0);
  endtask

  task automatic switch_to(input int n);
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel = n;
    last_rdata = '0;
    step();
  endtask

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [63:0] wd, input logic [63:0] rd);
    int ws, nb;
    logic flt;
    logic [15:0] ea;
    logic [63:0] er;
    ws  = ws_of(sel);
    nb  = 1 << sz;
    flt = ALIGN && ((int'(a) % nb) != 0);
    ea  = 16'(int'(a) - (int'(a) % nb));
    chk("idle_ready", o_ready, 1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; mem_rdata = {$urandom, $urandom};
    step();
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = 16'($urandom); req_wdata = {$urandom, $urandom};
    if (flt) begin
      chk("flt_valid", o_valid, 1); chk("flt_fault", o_fault, 1);
      chk("flt_cs", o_cs, 0);       chk("flt_rdata", o_rdata, 0);
      last_rdata = '0;
    end else begin
      for (int k = 0; k <= ws; k++) begin
        chk("acc_cs", o_cs, 1);       chk("acc_we", o_we, w);
        chk("acc_oe", o_oe, !w);      chk("acc_addr", o_addr, ea);
        chk("acc_size", o_size, sz);  chk("acc_wdata", o_wdata, wd);
        chk("acc_valid", o_valid, 0); chk("acc_ready", o_ready, 0);
        chk("acc_hold", o_rdata, last_rdata);
        mem_rdata = (k == ws) ? rd : {$urandom, $urandom};
        step();
      end
      er = w ? 64'd0 : ext_model(rd, sz, sg);
      chk("resp_valid", o_valid, 1); chk("resp_fault", o_fault, 0);
      chk("resp_rdata", o_rdata, er); chk("resp_cs", o_cs, 0);
      last_rdata = er;
    end
    step();
    chk("post_valid", o_valid, 0); chk("post_ready", o_ready, 1);
    chk("post_busy", o_busy, 0);   chk("post_hold", o_rdata, last_rdata);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_t[$];
    int nresp;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_reset();
    end
    step();
    rst_n = 1'b1;
    step();

    // WAIT_STATES=1 directed cases
    switch_to(1);
    run_txn(1'b1, 2'b11, 1'b0, 16'h0010, 64'h1122334455667788, 64'h0);
    chk("store_rdata_zero", o_rdata, 64'h0);
    run_txn(1'b0, 2'b00, 1'b1, 16'h0040, 64'h0, 64'h0000000000000080);
    chk("lb_signed", o_rdata, 64'hFFFFFFFFFFFFFF80);
    run_txn(1'b0, 2'b00, 1'b0, 16'h0041, 64'h0, 64'h0000000000000080);
    chk("lb_unsigned", o_rdata, 64'h0000000000000080);
    run_txn(1'b0, 2'b01, 1'b0, 16'h0003, 64'h0, 64'h000000000000BEEF);

    // WAIT_STATES=0: signed word, then req_valid held high
    switch_to(0);
    run_txn(1'b0, 2'b10, 1'b1, 16'h0100, 64'h0, 64'h0000000080000000);
    chk("lw_signed", o_rdata, 64'hFFFFFFFF80000000);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 16'h0020; mem_rdata = 64'h0123456789ABCDEF;
    nresp = 0;
    for (int c = 0; c < 15; c++) begin
      if (o_ready) acc_t.push_back(c);
      if (o_valid) nresp++;
      step();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (o_valid) nresp++;
      step();
    end
    chk("held_accepts", acc_t.size(), 5);
    for (int i = 1; i < acc_t.size(); i++) chk("held_gap", acc_t[i] - acc_t[i-1], 3);
    chk("held_resps", nresp, acc_t.size());
    chk("held_rdata", o_rdata, 64'h0123456789ABCDEF);
    last_rdata = 64'h0123456789ABCDEF;

    // WAIT_STATES=3: reset during the second ACCESS cycle
    switch_to(2);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 16'h0080; mem_rdata = 64'hDEADBEEFCAFEF00D;
    step();
    req_valid = 1'b0;
    step();
    chk("midacc_cs", o_cs, 1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    step();
    rst_n = 1'b1;
    nresp = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_valid) nresp++;
      step();
    end
    chk("abort_no_resp", nresp, 0);
    last_rdata = '0;
    run_txn(1'b0, 2'b10, 1'b0, 16'h0084, 64'h0, 64'h00000000FFFF1234);

    // Randomized traffic on every instance
    for (int s = 0; s < 3; s++) begin
      switch_to(s);
      for (int t = 0; t < 16; t++) begin
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        if (t % 3 == 0) rd[7] = 1'b1;
        run_txn(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                {$urandom, $urandom}, rd);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
